// File: rtl/dvp_rgb565_tx.sv
// DVP camera-bus frame generator: emits RGB565 pixels as byte pairs with vsync/href framing,
// sourcing pixels either from an external request/response port or an internal colour-bar pattern.
module dvp_rgb565_tx #(
  parameter int H_PIXEL  = 1024,
  parameter int V_PIXEL  = 768,
  parameter int H_BLANK  = 64,
  parameter int VS_LINES = 2,
  parameter int V_BP     = 4,
  parameter int V_FP     = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        gen_en,
  input  logic        pat_sel,
  output logic        pix_req,
  input  logic [15:0] pix_data,
  output logic        cam_vsync,
  output logic        cam_href,
  output logic [7:0]  cam_data,
  output logic        frame_done,
  output logic        busy
);

  localparam int L     = 2 * H_PIXEL + H_BLANK;
  localparam int HW    = $clog2(L);
  localparam int M1    = (VS_LINES > V_BP) ? VS_LINES : V_BP;
  localparam int M2    = (V_PIXEL > V_FP) ? V_PIXEL : V_FP;
  localparam int MAXL  = (M1 > M2) ? M1 : M2;
  localparam int LW    = (MAXL > 1) ? $clog2(MAXL) : 1;
  localparam int BAR_W = H_PIXEL / 8;
  localparam int BW    = (BAR_W > 1) ? $clog2(BAR_W) : 1;
  localparam bit NO_VFP = (V_FP == 32'sd0);

  localparam logic [HW-1:0] H_LAST    = HW'(L - 1);
  localparam logic [HW-1:0] H_REQ0    = HW'(L - 2);
  localparam logic [HW-1:0] H_ACT     = HW'(2 * H_PIXEL);
  localparam logic [HW-1:0] H_REQ_MAX = HW'(2 * H_PIXEL - 4);
  localparam logic [LW-1:0] VS_LAST   = LW'(VS_LINES - 1);
  localparam logic [LW-1:0] VBP_LAST  = LW'(V_BP - 1);
  localparam logic [LW-1:0] VPIX_LAST = LW'(V_PIXEL - 1);
  localparam logic [LW-1:0] VFP_LAST  = LW'(V_FP - 1);
  localparam logic [BW-1:0] BAR_LAST  = BW'(BAR_W - 1);

  typedef enum logic [2:0] {IDLE, VSYNC, VBP, ACTIVE, VFP} state_t;

  function automatic logic [15:0] bar_colour(input logic [3:0] idx);
    case (idx)
      4'd0:    return 16'hFFFF;
      4'd1:    return 16'hFFE0;
      4'd2:    return 16'h07FF;
      4'd3:    return 16'h07E0;
      4'd4:    return 16'hF81F;
      4'd5:    return 16'hF800;
      4'd6:    return 16'h001F;
      default: return 16'h0000;
    endcase
  endfunction

  state_t        state_r, nxt_state_s;
  logic [HW-1:0] h_cnt_r, nxt_h_s;
  logic [LW-1:0] line_cnt_r, nxt_line_s;
  logic          pat_r;
  logic [7:0]    lo_byte_r;
  logic [BW-1:0] bar_pos_r, cur_pos_s;
  logic [3:0]    bar_idx_r, cur_idx_s;
  logic          start_s, phase_last_s;
  logic          nxt_href_s, nxt_req_s, nxt_done_s;
  logic [15:0]   pixel_s;

  // Last line of the current phase
  always_comb begin
    phase_last_s = 1'b0;
    case (state_r)
      VSYNC:   phase_last_s = (line_cnt_r == VS_LAST);
      VBP:     phase_last_s = (line_cnt_r == VBP_LAST);
      ACTIVE:  phase_last_s = (line_cnt_r == VPIX_LAST);
      VFP:     phase_last_s = (line_cnt_r == VFP_LAST);
      default: phase_last_s = 1'b0;
    endcase
  end

  // Next position in the frame; outputs are registered from this look-ahead
  always_comb begin
    nxt_state_s = state_r;
    nxt_h_s     = h_cnt_r;
    nxt_line_s  = line_cnt_r;
    start_s     = 1'b0;
    if (state_r == IDLE) begin
      nxt_h_s    = '0;
      nxt_line_s = '0;
      if (gen_en) begin
        nxt_state_s = VSYNC;
        start_s     = 1'b1;
      end else begin
        nxt_state_s = IDLE;
      end
    end else if (h_cnt_r != H_LAST) begin
      nxt_h_s = h_cnt_r + HW'(1);
    end else if (!phase_last_s) begin
      nxt_h_s    = '0;
      nxt_line_s = line_cnt_r + LW'(1);
    end else begin
      nxt_h_s    = '0;
      nxt_line_s = '0;
      case (state_r)
        VSYNC:   nxt_state_s = VBP;
        VBP:     nxt_state_s = ACTIVE;
        ACTIVE:  nxt_state_s = NO_VFP ? (gen_en ? VSYNC : IDLE) : VFP;
        VFP:     nxt_state_s = gen_en ? VSYNC : IDLE;
        default: nxt_state_s = IDLE;
      endcase
      start_s = (nxt_state_s == VSYNC);
    end
  end

  // Output look-ahead: a request leads its high byte by two cycles, so pixel 0 is asked for
  // at the end of the preceding line's blanking
  always_comb begin
    nxt_href_s = (nxt_state_s == ACTIVE) && (nxt_h_s < H_ACT);
    nxt_req_s  = !pat_r &&
                 (((nxt_state_s == ACTIVE) && !nxt_h_s[0] && (nxt_h_s <= H_REQ_MAX)) ||
                  ((nxt_h_s == H_REQ0) &&
                   (((nxt_state_s == VBP) && (nxt_line_s == VBP_LAST)) ||
                    ((nxt_state_s == ACTIVE) && (nxt_line_s != VPIX_LAST)))));
    nxt_done_s = (nxt_h_s == H_LAST) &&
                 (((nxt_state_s == VFP) && (nxt_line_s == VFP_LAST)) ||
                  (NO_VFP && (nxt_state_s == ACTIVE) && (nxt_line_s == VPIX_LAST)));
    cur_idx_s  = (nxt_h_s == '0) ? 4'd0 : bar_idx_r;
    cur_pos_s  = (nxt_h_s == '0) ? '0 : bar_pos_r;
    pixel_s    = pat_r ? bar_colour(cur_idx_s) : pix_data;
  end

  // Frame state, counters and registered DVP outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      h_cnt_r    <= '0;
      line_cnt_r <= '0;
      pat_r      <= 1'b0;
      lo_byte_r  <= 8'h00;
      bar_pos_r  <= '0;
      bar_idx_r  <= 4'd0;
      cam_vsync  <= 1'b0;
      cam_href   <= 1'b0;
      cam_data   <= 8'h00;
      pix_req    <= 1'b0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state_r    <= nxt_state_s;
      h_cnt_r    <= nxt_h_s;
      line_cnt_r <= nxt_line_s;
      if (start_s) begin
        pat_r <= pat_sel;
      end
      cam_vsync  <= (nxt_state_s == VSYNC);
      cam_href   <= nxt_href_s;
      pix_req    <= nxt_req_s;
      frame_done <= nxt_done_s;
      busy       <= (nxt_state_s != IDLE);
      if (nxt_href_s && !nxt_h_s[0]) begin
        cam_data  <= pixel_s[15:8];
        lo_byte_r <= pixel_s[7:0];
        // Bar index saturates at 8, which maps to black
        if (cur_pos_s == BAR_LAST) begin
          bar_pos_r <= '0;
          bar_idx_r <= (cur_idx_s == 4'd8) ? 4'd8 : cur_idx_s + 4'd1;
        end else begin
          bar_pos_r <= cur_pos_s + BW'(1);
          bar_idx_r <= cur_idx_s;
        end
      end else if (nxt_href_s) begin
        cam_data <= lo_byte_r;
      end else begin
        cam_data <= 8'h00;
      end
    end
  end

endmodule

// File: tb/tb_dvp_rgb565_tx.sv
// Directed bench for dvp_rgb565_tx with a small 18-clock-line, 108-clock-frame configuration.
module tb_dvp_rgb565_tx;

  localparam int L     = 18;
  localparam int FRAME = 108;

  logic        clk = 1'b0;
  logic        rst_n, gen_en, pat_sel;
  logic [15:0] pix_data;
  logic        pix_req, cam_vsync, cam_href, frame_done, busy;
  logic [7:0]  cam_data;
  int          checks = 0;
  int          failures = 0;

  dvp_rgb565_tx #(
    .H_PIXEL(8), .V_PIXEL(3), .H_BLANK(2), .VS_LINES(1), .V_BP(1), .V_FP(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .gen_en(gen_en), .pat_sel(pat_sel),
    .pix_req(pix_req), .pix_data(pix_data), .cam_vsync(cam_vsync),
    .cam_href(cam_href), .cam_data(cam_data), .frame_done(frame_done), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] val(input int n);
    logic [7:0] a, b;
    a = 8'(17 + 5 * n);
    b = 8'(n) ^ 8'hC3;
    return {a, b};
  endfunction

  function automatic logic [15:0] bar(input int x);
    case (x)
      0: return 16'hFFFF;
      1: return 16'hFFE0;
      2: return 16'h07FF;
      3: return 16'h07E0;
      4: return 16'hF81F;
      5: return 16'hF800;
      6: return 16'h001F;
      default: return 16'h0000;
    endcase
  endfunction

  // Frame cycle t (1-based): lines 0 vsync, 1 back porch, 2..4 active, 5 front porch
  function automatic bit exp_href(input int t);
    int ln, h;
    ln = (t - 1) / L;
    h  = (t - 1) % L;
    return (ln >= 2) && (ln <= 4) && (h < 16);
  endfunction

  task automatic check_idle(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      checks++;
      if ({cam_vsync, cam_href, cam_data, pix_req, frame_done, busy} !== 13'h0) begin
        failures++;
        $display("FAIL %s cycle %0d: outputs=%h required=0000", tag, i,
                 {cam_vsync, cam_href, cam_data, pix_req, frame_done, busy});
      end
      @(negedge clk);
    end
  endtask

  task automatic start_frame(input bit pat);
    @(negedge clk);
    pat_sel  = pat;
    gen_en   = 1'b1;
    pix_data = 16'hDEAD;
    @(negedge clk);
  endtask

  // Called at the negedge inside frame cycle 1; returns at the negedge after cycle stop_t
  task automatic check_frame(input string tag, input bit pat, input bit cdata,
                             input int gen_until, input int flip_t, input int stop_t);
    int nreq, vs, bursts;
    bit prev_req, prev_href;
    nreq = 0; vs = 0; bursts = 0; prev_req = 1'b0; prev_href = 1'b0;
    for (int t = 1; t <= stop_t; t++) begin
      int ln, h, g;
      logic [15:0] px;
      logic [7:0] eb;
      bit eh, er;
      ln = (t - 1) / L;
      h  = (t - 1) % L;
      g  = (ln - 2) * 8 + h / 2;
      eh = exp_href(t);
      er = !pat && exp_href(t + 2) && ((((t + 1) % L) % 2) == 0);
      px = pat ? bar(h / 2) : (cdata ? 16'hA55A : val(g));
      eb = !eh ? 8'h00 : (((h % 2) == 0) ? px[15:8] : px[7:0]);
      checks++;
      if (cam_vsync !== (t <= L)) begin
        failures++;
        $display("FAIL %s vsync t=%0d: got %b required %b", tag, t, cam_vsync, (t <= L));
      end
      checks++;
      if (cam_href !== eh) begin
        failures++;
        $display("FAIL %s href t=%0d: got %b required %b", tag, t, cam_href, eh);
      end
      checks++;
      if (cam_data !== eb) begin
        failures++;
        $display("FAIL %s data t=%0d: got %h required %h", tag, t, cam_data, eb);
      end
      checks++;
      if (pix_req !== er) begin
        failures++;
        $display("FAIL %s pix_req t=%0d: got %b required %b", tag, t, pix_req, er);
      end
      checks++;
      if (frame_done !== (t == FRAME)) begin
        failures++;
        $display("FAIL %s frame_done t=%0d: got %b required %b", tag, t, frame_done, (t == FRAME));
      end
      checks++;
      if (busy !== 1'b1) begin
        failures++;
        $display("FAIL %s busy t=%0d: got %b required 1", tag, t, busy);
      end
      if (cam_vsync === 1'b1) vs++;
      if (cam_href === 1'b1 && !prev_href) bursts++;
      prev_href = (cam_href === 1'b1);
      gen_en = (t < gen_until);
      if (t == flip_t) pat_sel = ~pat_sel;
      pix_data = cdata ? 16'hA55A : (prev_req ? val(nreq - 1) : 16'hDEAD);
      prev_req = (pix_req === 1'b1);
      if (prev_req) nreq++;
      @(negedge clk);
    end
    if (stop_t == FRAME) begin
      checks++;
      if (vs != L || nreq != (pat ? 0 : 24) || bursts != 3) begin
        failures++;
        $display("FAIL %s totals: vsync=%0d req=%0d bursts=%0d required %0d/%0d/3",
                 tag, vs, nreq, bursts, L, (pat ? 0 : 24));
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; gen_en = 1'b0; pat_sel = 1'b0; pix_data = 16'h0000;
    repeat (3) @(negedge clk);
    check_idle("reset", 1);
    rst_n = 1'b1;
    check_idle("idle_after_reset", 3);
  endtask

  task automatic test_ext_frame;
    start_frame(1'b0);
    check_frame("ext", 1'b0, 1'b0, 0, 0, FRAME);
    check_idle("ext_end", 4);
  endtask

  task automatic test_const_data;
    start_frame(1'b0);
    check_frame("a55a", 1'b0, 1'b1, 0, 0, FRAME);
    check_idle("a55a_end", 2);
  endtask

  task automatic test_pattern;
    start_frame(1'b1);
    check_frame("pattern", 1'b1, 1'b0, 0, 40, FRAME);
    check_idle("pattern_end", 2);
  endtask

  task automatic test_pat_toggle;
    start_frame(1'b0);
    check_frame("toggle", 1'b0, 1'b0, 0, 30, FRAME);
    check_idle("toggle_end", 2);
  endtask

  task automatic test_back_to_back;
    start_frame(1'b0);
    check_frame("b2b_f1", 1'b0, 1'b0, 1000, 0, FRAME);
    check_frame("b2b_f2", 1'b0, 1'b0, 50, 0, FRAME);
    check_idle("b2b_end", 4);
  endtask

  task automatic test_reset_mid;
    start_frame(1'b0);
    check_frame("rst_mid", 1'b0, 1'b0, 0, 0, 60);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({cam_vsync, cam_href, cam_data, pix_req, frame_done, busy} !== 13'h0) begin
      failures++;
      $display("FAIL rst_async: outputs=%h required=0000",
               {cam_vsync, cam_href, cam_data, pix_req, frame_done, busy});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check_idle("rst_hold_idle", 130);
    start_frame(1'b0);
    check_frame("rst_restart", 1'b0, 1'b0, 0, 0, FRAME);
    check_idle("rst_restart_end", 2);
  endtask

  initial begin
    test_reset();
    test_ext_frame();
    test_const_data();
    test_pattern();
    test_pat_toggle();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
